ps2_key_state_tracker: RTL and testbench

Receives the raw PS/2 keyboard line (set-2 scan codes), decodes make/break sequences and maintains the registered key-state vector that the main state handler consumes as its keyboard input. It also produces the one-cycle release pulse embedded in that vector, plus a press/release event strobe. It sits between the board PS/2 pins and the main state handler / FSM layer.

---
 rtl/ps2_key_state_tracker_pkg.sv | 90 +++++++++
 rtl/ps2_key_state_tracker_frame_rx.sv | 106 ++++++++++
 rtl/ps2_key_state_tracker.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_state_tracker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_state_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_state_tracker_pkg
//
// Shared definitions for the PS/2 key-state tracker:
//   - set-2 scan-code constants (break/extend prefixes and the 26 mapped keys)
//   - key index constants (bit positions inside key_state)
//   - key_state width, PS/2 frame length
//   - decoder FSM state type and the scan-code lookup result type
// ---------------------------------------------------------------------------
package ps2_key_state_tracker_pkg;

    localparam int NUMBEROFKEYBOARDINPUTS = 27;
    localparam int PS2_FRAME_BITS         = 11;

    // Prefix bytes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXTEND = 8'hE0;

    // Note-key scan codes (lower row + number row, piano layout)
    localparam logic [7:0] SC_TAB       = 8'h0D;
    localparam logic [7:0] SC_Q         = 8'h15;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_E         = 8'h24;
    localparam logic [7:0] SC_R         = 8'h2D;
    localparam logic [7:0] SC_T         = 8'h2C;
    localparam logic [7:0] SC_Y         = 8'h35;
    localparam logic [7:0] SC_U         = 8'h3C;
    localparam logic [7:0] SC_I         = 8'h43;
    localparam logic [7:0] SC_O         = 8'h44;
    localparam logic [7:0] SC_P         = 8'h4D;
    localparam logic [7:0] SC_LBRACKET  = 8'h54;
    localparam logic [7:0] SC_RBRACKET  = 8'h5B;
    localparam logic [7:0] SC_BACKSLASH = 8'h5D;
    localparam logic [7:0] SC_1         = 8'h16;
    localparam logic [7:0] SC_2         = 8'h1E;
    localparam logic [7:0] SC_4         = 8'h25;
    localparam logic [7:0] SC_5         = 8'h2E;
    localparam logic [7:0] SC_6         = 8'h36;
    localparam logic [7:0] SC_8         = 8'h3E;
    localparam logic [7:0] SC_9         = 8'h46;
    localparam logic [7:0] SC_MINUS     = 8'h4E;
    localparam logic [7:0] SC_EQUALS    = 8'h55;
    localparam logic [7:0] SC_BACKSPACE = 8'h66;

    // Other mapped keys
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ESCAPE = 8'h76;

    // Bit positions inside key_state
    localparam logic [4:0] keyTab          = 5'd0;
    localparam logic [4:0] keyQ            = 5'd1;
    localparam logic [4:0] keyW            = 5'd2;
    localparam logic [4:0] keyE            = 5'd3;
    localparam logic [4:0] keyR            = 5'd4;
    localparam logic [4:0] keyT            = 5'd5;
    localparam logic [4:0] keyY            = 5'd6;
    localparam logic [4:0] keyU            = 5'd7;
    localparam logic [4:0] keyI            = 5'd8;
    localparam logic [4:0] keyO            = 5'd9;
    localparam logic [4:0] keyP            = 5'd10;
    localparam logic [4:0] keyLBracket     = 5'd11;
    localparam logic [4:0] keyRBracket     = 5'd12;
    localparam logic [4:0] keyBackslash    = 5'd13;
    localparam logic [4:0] key1            = 5'd14;
    localparam logic [4:0] key2            = 5'd15;
    localparam logic [4:0] key4            = 5'd16;
    localparam logic [4:0] key5            = 5'd17;
    localparam logic [4:0] key6            = 5'd18;
    localparam logic [4:0] key8            = 5'd19;
    localparam logic [4:0] key9            = 5'd20;
    localparam logic [4:0] keyMinus        = 5'd21;
    localparam logic [4:0] keyEquals       = 5'd22;
    localparam logic [4:0] keyBackspace    = 5'd23;
    localparam logic [4:0] keySpacebar     = 5'd24;
    localparam logic [4:0] keyEscape       = 5'd25;
    localparam logic [4:0] keyReleasePulse = 5'd26;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } decState_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] index;
    } keyMap_t;

endpackage

// File: rtl/ps2_key_state_tracker_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
//
// Receives one PS/2 device-to-host frame: start(0), 8 data bits LSB first,
// odd parity, stop(1). Both pins are brought in through 2-FF synchronisers
// and data is sampled on the synchronised falling edge of ps2_clk.
//
// Ports
//   clk          system clock
//   resetn       synchronous active-low reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_dat      raw PS/2 data pin (asynchronous)
//   byte_valid   one-cycle strobe, byte_data holds a good byte
//   byte_data    received byte
//   frame_error  one-cycle strobe on bad start/stop/parity
//
// Build option: PREFIX_TIMEOUT_EN clears a stalled partial frame when
// ps2_clk stays high for PREFIX_TIMEOUT cycles mid-frame.
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_key_state_tracker_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_error
);

    logic [2:0]                    clkSync;   // [0],[1] synchroniser, [2] previous value
    logic [1:0]                    datSync;
    logic [3:0]                    bitCount;
    logic [PS2_FRAME_BITS-2:0]     shiftReg;  // first ten bits of the frame
    logic [PS2_FRAME_BITS-1:0]     frame;
    logic                          fallEdge;
    logic                          lastBit;
    logic                          frameGood;
    logic                          stallClear;

    assign fallEdge  = clkSync[2] & ~clkSync[1];
    assign lastBit   = (bitCount == 4'(PS2_FRAME_BITS - 1));
    // The stop bit is taken straight from the synchroniser so the whole
    // frame can be judged on the final falling edge.
    assign frame     = {datSync[1], shiftReg};
    assign frameGood = ~frame[0] & frame[PS2_FRAME_BITS-1] & (^frame[9:1]);

`ifdef PREFIX_TIMEOUT_EN
    localparam int STALL_W = $clog2(PREFIX_TIMEOUT + 1);
    logic [STALL_W-1:0] stallTimer;

    assign stallClear = (stallTimer == STALL_W'(PREFIX_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn || bitCount == 4'd0 || !clkSync[1] || stallClear) begin
            stallTimer <= '0;
        end else begin
            stallTimer <= stallTimer + 1'b1;
        end
    end
`else
    assign stallClear = 1'b0;
`endif

    // Idle line is high; resetting the clock chain high avoids a false edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clkSync <= '1;
        end else begin
            clkSync <= {clkSync[1:0], ps2_clk};
        end
    end

    always_ff @(posedge clk) begin
        datSync <= {datSync[0], ps2_dat};
        if (fallEdge) begin
            shiftReg <= {datSync[1], shiftReg[PS2_FRAME_BITS-2:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bitCount    <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            byte_valid  <= fallEdge & lastBit & frameGood;
            frame_error <= fallEdge & lastBit & ~frameGood;
            if (stallClear) begin
                bitCount <= '0;
            end else if (fallEdge) begin
                bitCount <= lastBit ? 4'd0 : bitCount + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fallEdge && lastBit && frameGood) begin
            byte_data <= frame[8:1];
        end
    end

endmodule

// File: rtl/ps2_key_state_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_state_tracker
//
// Decodes PS/2 set-2 make/break sequences into a registered key-state vector
// for the main state handler. Bits 0-23 are note keys, 24 spacebar,
// 25 escape, 26 a one-cycle pulse on every effective key release.
//
// Ports
//   clk                system clock
//   resetn             synchronous active-low reset
//   ps2_clk, ps2_dat   raw PS/2 pins (asynchronous)
//   key_state          held-key bits plus release-pulse bit
//   key_event          one-cycle strobe on any mapped state change
//   key_event_index    key index of the event
//   key_event_release  1 = release, 0 = press (qualified by key_event)
//   frame_error        one-cycle strobe on a bad PS/2 frame
//
// Build option: PREFIX_TIMEOUT_EN returns the decoder to IDLE when a prefix
// byte (E0/F0) is not followed by another byte within PREFIX_TIMEOUT cycles.
// ---------------------------------------------------------------------------
module ps2_key_state_tracker #(
    parameter int NUMBEROFKEYBOARDINPUTS = ps2_key_state_tracker_pkg::NUMBEROFKEYBOARDINPUTS,
    parameter int PREFIX_TIMEOUT         = 50000
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              ps2_clk,
    input  logic                              ps2_dat,
    output logic [NUMBEROFKEYBOARDINPUTS-1:0] key_state,
    output logic                              key_event,
    output logic [4:0]                        key_event_index,
    output logic                              key_event_release,
    output logic                              frame_error
);

    import ps2_key_state_tracker_pkg::*;

    logic                              byteValid;
    logic [7:0]                        byteData;
    keyMap_t                           byteMap;
    decState_t                         state;
    decState_t                         stateNext;
    logic                              doPress;
    logic                              doRelease;
    logic                              prefixExpired;
    logic [NUMBEROFKEYBOARDINPUTS-2:0] keyHeld;
    logic                              relPulse;

    function automatic keyMap_t mapScanCode(input logic [7:0] code);
        keyMap_t m;
        m.hit   = 1'b1;
        m.index = '0;
        case (code)
            SC_TAB:       m.index = keyTab;
            SC_Q:         m.index = keyQ;
            SC_W:         m.index = keyW;
            SC_E:         m.index = keyE;
            SC_R:         m.index = keyR;
            SC_T:         m.index = keyT;
            SC_Y:         m.index = keyY;
            SC_U:         m.index = keyU;
            SC_I:         m.index = keyI;
            SC_O:         m.index = keyO;
            SC_P:         m.index = keyP;
            SC_LBRACKET:  m.index = keyLBracket;
            SC_RBRACKET:  m.index = keyRBracket;
            SC_BACKSLASH: m.index = keyBackslash;
            SC_1:         m.index = key1;
            SC_2:         m.index = key2;
            SC_4:         m.index = key4;
            SC_5:         m.index = key5;
            SC_6:         m.index = key6;
            SC_8:         m.index = key8;
            SC_9:         m.index = key9;
            SC_MINUS:     m.index = keyMinus;
            SC_EQUALS:    m.index = keyEquals;
            SC_BACKSPACE: m.index = keyBackspace;
            SC_SPACE:     m.index = keySpacebar;
            SC_ESCAPE:    m.index = keyEscape;
            default:      m.hit   = 1'b0;
        endcase
        return m;
    endfunction

    ps2_frame_rx #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT)
    ) frameRx (
        .clk         (clk),
        .resetn      (resetn),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .byte_valid  (byteValid),
        .byte_data   (byteData),
        .frame_error (frame_error)
    );

    assign byteMap = mapScanCode(byteData);

`ifdef PREFIX_TIMEOUT_EN
    localparam int TIMER_W = $clog2(PREFIX_TIMEOUT + 1);
    logic [TIMER_W-1:0] prefixTimer;

    // Restarts on every byte, so entering EXT_BREAK from EXT starts afresh.
    assign prefixExpired = (state != IDLE) && (prefixTimer == TIMER_W'(PREFIX_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn || state == IDLE || byteValid) begin
            prefixTimer <= '0;
        end else if (!prefixExpired) begin
            prefixTimer <= prefixTimer + 1'b1;
        end
    end
`else
    assign prefixExpired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Presses of held keys (typematic) and releases of idle keys are dropped
    // here so that they produce neither an event nor a pulse.
    always_comb begin
        stateNext = state;
        doPress   = 1'b0;
        doRelease = 1'b0;
        if (byteValid) begin
            case (state)
                IDLE: begin
                    if (byteData == SC_BREAK) begin
                        stateNext = BREAK;
                    end else if (byteData == SC_EXTEND) begin
                        stateNext = EXT;
                    end else if (byteMap.hit && !keyHeld[byteMap.index]) begin
                        doPress = 1'b1;
                    end
                end
                BREAK: begin
                    stateNext = IDLE;
                    if (byteMap.hit && keyHeld[byteMap.index]) begin
                        doRelease = 1'b1;
                    end
                end
                EXT: begin
                    stateNext = (byteData == SC_BREAK) ? EXT_BREAK : IDLE;
                end
                EXT_BREAK: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end else if (prefixExpired) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            keyHeld           <= '0;
            relPulse          <= 1'b0;
            key_event         <= 1'b0;
            key_event_index   <= '0;
            key_event_release <= 1'b0;
        end else begin
            relPulse  <= doRelease;
            key_event <= doPress | doRelease;
            if (doPress || doRelease) begin
                key_event_index   <= byteMap.index;
                key_event_release <= doRelease;
            end
            if (doPress) begin
                keyHeld[byteMap.index] <= 1'b1;
            end else if (doRelease) begin
                keyHeld[byteMap.index] <= 1'b0;
            end
        end
    end

    assign key_state = {relPulse, keyHeld};

endmodule

// File: tb/tb_ps2_key_state_tracker.sv
module tb_ps2_key_state_tracker;

    localparam int PT = 2000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [26:0] key_state;
    logic        key_event;
    logic [4:0]  key_event_index;
    logic        key_event_release;
    logic        frame_error;

    int total = 0;
    int bad = 0;

    // Observation counters, sampled on the falling clock edge
    int         evCnt = 0;
    int         relCnt = 0;
    int         errCnt = 0;
    logic [4:0] lastIdx = '0;
    logic       lastRel = 1'b0;

    // Reference model: held keys and pending prefix bytes
    logic [25:0] mHeld = '0;
    logic [7:0]  pfx[$];
    logic [7:0]  codeTab [26] = '{8'h0D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                                  8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B, 8'h5D, 8'h16, 8'h1E,
                                  8'h25, 8'h2E, 8'h36, 8'h3E, 8'h46, 8'h4E, 8'h55, 8'h66,
                                  8'h29, 8'h76};
    logic [7:0]  otherTab [6] = '{8'h1C, 8'h5A, 8'h26, 8'h45, 8'hF0, 8'hE0};

    ps2_key_state_tracker #(
        .NUMBEROFKEYBOARDINPUTS (27),
        .PREFIX_TIMEOUT         (PT)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ps2_clk           (ps2_clk),
        .ps2_dat           (ps2_dat),
        .key_state         (key_state),
        .key_event         (key_event),
        .key_event_index   (key_event_index),
        .key_event_release (key_event_release),
        .frame_error       (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event === 1'b1) begin
            evCnt   <= evCnt + 1;
            lastIdx <= key_event_index;
            lastRel <= key_event_release;
        end
        if (key_state[26] === 1'b1) relCnt <= relCnt + 1;
        if (frame_error === 1'b1) errCnt <= errCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sendBits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            repeat (5) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (5) @(negedge clk);
        end
    endtask

    function automatic logic [10:0] mkFrame(input logic [7:0] b, input bit badPar);
        logic par;
        par = ~(^b) ^ badPar;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Applies one received byte to the model: press/release derived from the
    // prefixes collected since the last non-prefix byte.
    task automatic modelByte(input logic [7:0] b, input bit badf,
                             output int ev, output int idx, output int rel);
        bit ext;
        bit brk;
        ev = 0; idx = 0; rel = 0;
        if (badf) return;
        if (b == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
            pfx.push_back(b);
            return;
        end
        if (b == 8'hE0 && pfx.size() == 0) begin
            pfx.push_back(b);
            return;
        end
        ext = (pfx.size() > 0) && (pfx[0] == 8'hE0);
        brk = 1'b0;
        foreach (pfx[i]) if (pfx[i] == 8'hF0) brk = 1'b1;
        pfx.delete();
        if (ext) return;
        idx = -1;
        for (int k = 0; k < 26; k++) if (codeTab[k] == b) idx = k;
        if (idx < 0) begin
            idx = 0;
            return;
        end
        if (brk && mHeld[idx]) begin
            mHeld[idx] = 1'b0;
            ev = 1; rel = 1;
        end else if (!brk && !mHeld[idx]) begin
            mHeld[idx] = 1'b1;
            ev = 1;
        end
    endtask

    task automatic sendCheck(input logic [7:0] b, input bit badf, input string tag);
        int ev0, rl0, er0;
        int ev, idx, rel;
        ev0 = evCnt; rl0 = relCnt; er0 = errCnt;
        sendBits(mkFrame(b, badf), 11);
        repeat (20) @(negedge clk);
        modelByte(b, badf, ev, idx, rel);
        check({tag, "_events"}, evCnt - ev0, ev);
        check({tag, "_relpulse"}, relCnt - rl0, (ev != 0 && rel != 0) ? 1 : 0);
        check({tag, "_ferr"}, errCnt - er0, badf ? 1 : 0);
        check({tag, "_state"}, {5'd0, key_state}, {6'd0, mHeld});
        if (ev != 0) begin
            check({tag, "_index"}, {27'd0, lastIdx}, idx);
            check({tag, "_release"}, {31'd0, lastRel}, rel);
        end
    endtask

    initial begin
        int pick;
        logic [7:0] rb;
        pfx.delete();
        repeat (5) @(negedge clk);
        check("rst_key_state", {5'd0, key_state}, 0);
        check("rst_key_event", {31'd0, key_event}, 0);
        check("rst_index", {27'd0, key_event_index}, 0);
        check("rst_release", {31'd0, key_event_release}, 0);
        check("rst_frame_error", {31'd0, frame_error}, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        sendCheck(8'h15, 1'b0, "make15");
        sendCheck(8'h15, 1'b0, "typ15a");
        sendCheck(8'h15, 1'b0, "typ15b");
        sendCheck(8'hF0, 1'b0, "brkpfx");
        sendCheck(8'h15, 1'b0, "brk15");
        sendCheck(8'h29, 1'b0, "make29");
        sendCheck(8'h0D, 1'b0, "make0D");
        sendCheck(8'hF0, 1'b0, "brkpfx2");
        sendCheck(8'h29, 1'b0, "brk29");
        sendCheck(8'hE0, 1'b0, "extpfx");
        sendCheck(8'hF0, 1'b0, "extbrk");
        sendCheck(8'h29, 1'b0, "ext29");
        sendCheck(8'h29, 1'b0, "after_ext29");
        sendCheck(8'h15, 1'b1, "parity15");
        sendCheck(8'hF0, 1'b0, "brk_release_only");
        sendCheck(8'h76, 1'b0, "brk_idle76");

        // Reset in the middle of a frame drops the partial frame and all keys
        sendBits(mkFrame(8'h1D, 1'b0), 5);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        mHeld = '0;
        pfx.delete();
        repeat (5) @(negedge clk);
        check("midrst_key_state", {5'd0, key_state}, 0);
        sendCheck(8'h1D, 1'b0, "after_midrst");

`ifdef PREFIX_TIMEOUT_EN
        sendCheck(8'hF0, 1'b0, "to_pfx");
        repeat (PT + 50) @(negedge clk);
        pfx.delete();
        sendCheck(8'h15, 1'b0, "to_make15");
`endif

        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6) rb = codeTab[$urandom_range(0, 25)];
            else rb = otherTab[$urandom_range(0, 5)];
            sendCheck(rb, ($urandom_range(0, 9) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
